// File: rtl/udm_bus_csr_responder_if.sv
// -----------------------------------------------------------------------------
// udm_bus_csr_responder_if
// Request/ack/resp bus between a udm master and a CSR responder.
//   req    request valid, held with we/addr/be/wdata until ack
//   we     1 = write, 0 = read
//   addr   byte address, bits [1:0] ignored by responders
//   be     byte enables for writes
//   wdata  write data
//   ack    request accepted in this cycle (req && ack)
//   resp   read response valid, one-cycle pulse per accepted read
//   rdata  read data, valid with resp, otherwise 0
// -----------------------------------------------------------------------------
interface udm_bus_csr_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, resp, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, resp, rdata
  );
endinterface

// File: rtl/udm_bus_csr_responder.sv
// -----------------------------------------------------------------------------
// udm_bus_csr_responder
// Slave end of the udm request/ack/resp bus. Decodes word addresses into a
// small CSR bank: LED register, synchronised switch input, scratch register,
// free-running cycle counter and a constant ID. Requests are acknowledged
// after ACK_WAIT wait cycles; reads return through a RD_LATENCY-deep pipe.
// Ports:
//   clk_i   single clock
//   rst_i   asynchronous reset, active-high
//   bus     request/ack/resp bus (slave modport)
//   sw_i    asynchronous switch inputs, SW_WIDTH bits
//   led_o   LED register, LED_WIDTH bits
// -----------------------------------------------------------------------------
module udm_bus_csr_responder #(
  parameter int          LED_WIDTH  = 16,
  parameter int          SW_WIDTH   = 16,
  parameter int          ACK_WAIT   = 0,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] ID_VALUE   = 32'h55444D31
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  udm_bus_csr_responder_if.slave    bus,
  input  logic [SW_WIDTH-1:0]       sw_i,
  output logic [LED_WIDTH-1:0]      led_o
);

  localparam logic [29:0] WORD_LED     = 30'h0;
  localparam logic [29:0] WORD_SW      = 30'h1;
  localparam logic [29:0] WORD_SCRATCH = 30'h2;
  localparam logic [29:0] WORD_CNT     = 30'h3;
  localparam logic [29:0] WORD_ID      = 30'h4;

  logic [3:0]           wcnt;
  logic                 ack;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [29:0]          word;
  logic [31:0]          wmask;
  logic [LED_WIDTH-1:0] led_q;
  logic [SW_WIDTH-1:0]  sw_meta;
  logic [SW_WIDTH-1:0]  sw_sync;
  logic [31:0]          scratch;
  logic [31:0]          cnt;
  logic [31:0]          rd_data;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [31:0]          pipe_dat [RD_LATENCY];
  logic                 unused_addr;

  assign word        = bus.addr[31:2];
  assign unused_addr = ^bus.addr[1:0];
  assign wmask       = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};

  // Ack is combinational so a request can be taken in the cycle it appears
  // when no wait states are configured; it is forced low while in reset.
  assign ack     = bus.req && (wcnt == 4'(ACK_WAIT)) && !rst_i;
  assign bus.ack = ack;
  assign wr_acc  = ack && bus.we;
  assign rd_acc  = ack && !bus.we;

  // Wait-state counter: counts cycles of a pending request, restarts when
  // the request is dropped or accepted.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt <= '0;
    end else if (!bus.req || ack) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 4'd1;
    end
  end

  // Two-flop synchroniser for the switch inputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_i;
      sw_sync <= sw_meta;
    end
  end

  // Register bank. The counter write wins over the increment so the written
  // value is visible unchanged in the following cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led_q   <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else begin
      if (wr_acc && word == WORD_LED) begin
        led_q <= (led_q & ~wmask[LED_WIDTH-1:0]) | (bus.wdata[LED_WIDTH-1:0] & wmask[LED_WIDTH-1:0]);
      end
      if (wr_acc && word == WORD_SCRATCH) begin
        scratch <= (scratch & ~wmask) | (bus.wdata & wmask);
      end
      if (wr_acc && word == WORD_CNT) begin
        cnt <= (cnt & ~wmask) | (bus.wdata & wmask);
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  assign led_o = led_q;

  // Read snapshot, taken from the current (pre-write) register values.
  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational; an unassigned path would infer a latch.
  always_comb begin
    rd_data = '0;
    case (word)
      WORD_LED:     rd_data = 32'(led_q);
      WORD_SW:      rd_data = 32'(sw_sync);
      WORD_SCRATCH: rd_data = scratch;
      WORD_CNT:     rd_data = cnt;
      WORD_ID:      rd_data = ID_VALUE;
      default:      rd_data = '0;
    endcase
  end

  // Fixed-length read pipe; it never stalls. Data stages carry 0 when no
  // read occupies them, so rdata is 0 whenever resp is low.
  // NOTE: the pipe data array is reset as well, since rdata must read 0
  // straight out of reset and in-flight reads must be dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_acc;
      pipe_dat[0] <= rd_acc ? rd_data : 32'd0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign bus.resp  = pipe_vld[RD_LATENCY-1];
  assign bus.rdata = pipe_dat[RD_LATENCY-1];

endmodule
